// File: rtl/sync_fifo_lvl.sv
// Synchronous FIFO with occupancy level, threshold flags and sticky overflow/underflow errors.
// Optional macro FIFO_FWFT_EN makes the head word visible on out without waiting for a pop.
module sync_fifo_lvl #(
  parameter int WIDTH    = 8,
  parameter int BASE     = 9,
  parameter int AF_LEVEL = (2**BASE) - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_err,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             is_empty,
  output logic             is_full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [BASE:0]    level,
  output logic             overflow,
  output logic             underflow
);

  localparam int            DEPTH   = 2**BASE;
  localparam logic [BASE:0] DEPTH_L = (BASE+1)'(DEPTH);
  localparam logic [BASE:0] AF_L    = AF_LEVEL[BASE:0];
  localparam logic [BASE:0] AE_L    = AE_LEVEL[BASE:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [BASE-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [BASE:0]    level_nxt;
  logic             push_ok, pop_ok;

  // A full FIFO still takes a push when the same cycle frees a slot.
  always_comb begin
    pop_ok     = pop && (level != '0);
    push_ok    = push && ((level != DEPTH_L) || pop_ok);
    level_nxt  = level;
    if (push_ok && !pop_ok)
      level_nxt = level + 1'b1;
    else if (pop_ok && !push_ok)
      level_nxt = level - 1'b1;
    rd_ptr_nxt = pop_ok ? rd_ptr + 1'b1 : rd_ptr;
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      is_empty     <= 1'b1;
      is_full      <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      rd_ptr       <= rd_ptr_nxt;
      level        <= level_nxt;
      is_empty     <= (level_nxt == '0);
      is_full      <= (level_nxt == DEPTH_L);
      almost_empty <= (level_nxt <= AE_L);
      almost_full  <= (level_nxt >= AF_L);
      if (clr_err)
        overflow <= 1'b0;
      else if (push && !push_ok)
        overflow <= 1'b1;
      if (clr_err)
        underflow <= 1'b0;
      else if (pop && (level == '0))
        underflow <= 1'b1;
    end
  end

`ifdef FIFO_FWFT_EN
  logic [WIDTH-1:0] head_nxt;

  // The next head may be the word being written this very cycle.
  always_comb begin
    head_nxt = mem[rd_ptr_nxt];
    if (push_ok && (wr_ptr == rd_ptr_nxt))
      head_nxt = in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (level_nxt != '0)
        out <= head_nxt;
      out_valid <= (level_nxt != '0);
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (pop_ok)
        out <= mem[rd_ptr];
      out_valid <= pop_ok;
    end
  end
`endif

endmodule
